sr_latch_ctrl: RTL and testbench
================================

# sr_latch_ctrl

Sequencing controller for a bank of gated SR latches. Arbitrates set/reset write requests from several requesters and drives the shared R/S/enable lines of the bank. Each access follows a fixed setup, enable-pulse and hold sequence, so R/S are stable for the whole enable window. It sits between register-style control logic and the latch bank, with one `sr_latch` instance per bit.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `N_LATCH`, 8, number of latches in the bank
- `IDXW`, 3, latch index width, $clog2(N_LATCH), minimum 1
- `PULSE_CYC`, 2, enable pulse length in cycles (≥1)

Ports (fixed: one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  per-requester request, level, held until ack
- `op`  in  N_REQ  per-requester operation, 1 = set (Q←1), 0 = reset (Q←0)
- `idx`  in  N_REQ*IDXW  per-requester latch index, requester k at bits [k*IDXW +: IDXW]
- `ack`  out  N_REQ  one-cycle completion pulse, one-hot
- `err`  out  1  one-cycle pulse with ack when the granted idx ≥ N_LATCH
- `busy`  out  1  high in every state except IDLE
- `grant_id`  out  $clog2(N_REQ)  index of the current grantee, valid while busy
- `latch_R`  out  N_LATCH  reset inputs to the bank
- `latch_S`  out  N_LATCH  set inputs to the bank
- `latch_en`  out  N_LATCH  enable inputs to the bank

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
- IDLE: if any `req` is high, a round-robin pick starts at `ptr+1` mod N_REQ. The controller registers `grant_id`, `op[g]` and `idx[g]`, then goes to SETUP. With no request, it stays in IDLE.
- SETUP (1 cycle): drive the selected latch with `latch_S[i]=op`, `latch_R[i]=~op`; `latch_en` stays 0.
- PULSE (PULSE_CYC cycles, internal down-counter): R/S held, `latch_en[i]=1`.
- HOLD (1 cycle): `latch_en` 0, R/S still held.
- DONE (1 cycle): `ack[g]=1`, `err` as computed, all R/S/en 0, `ptr←g`, then go to IDLE.
- Only the selected latch index is ever driven. All other bits of `latch_R`, `latch_S` and `latch_en` are 0 at all times. R and S are never both 1.
- Invalid idx (≥ N_LATCH): the full sequence and timing still run, but no latch bit is driven, and `err` pulses in DONE.
- Captured op/idx are used for the whole access. Changes on `op`/`idx`/`req` after the grant are ignored until DONE.
- Requester rule: `req` must be low in the cycle after its `ack`. The controller arbitrates only in IDLE, which always follows DONE, so a requester that drops `req` on time is never double-served.
- Fairness: a requester that holds `req` is granted within N_REQ accesses.

## Timing
- Reset (async, immediate): state IDLE, `ptr=N_REQ-1` so requester 0 has first priority, and counter 0. All outputs are 0: `ack`, `err`, `busy`, `grant_id`, `latch_R`, `latch_S`, `latch_en`.
- Reset during SETUP, PULSE or HOLD aborts the access. `latch_en` drops in the same instant, and no ack is issued. The latch keeps whatever it captured.
- All outputs are registered or decoded from registered state and capture registers only. There is no combinational path from `req`, `op` or `idx` to any output.
- Latency, with cycle 0 = first IDLE cycle where a req is high:
  - SETUP in cycle 1
  - PULSE in cycles 2 … 1+PULSE_CYC
  - HOLD in cycle 2+PULSE_CYC
  - DONE/ack in cycle 3+PULSE_CYC (cycle 5 for the default)
  - earliest next grant in IDLE at cycle 4+PULSE_CYC
- Throughput: one access per PULSE_CYC+4 cycles.
- Simultaneous requests: one grant per IDLE cycle. Losers keep `req` high and wait.

## Structure
- Package `sr_ctrl_pkg`:
  - state enum (IDLE, SETUP, PULSE, HOLD, DONE)
  - constants `OP_RESET=1'b0`, `OP_SET=1'b1`
- Sub-module `rr_arbiter`, parameterised on N_REQ:
  - inputs: `req`, `ptr`
  - outputs: `gnt_valid`, `gnt_id`, combinational
  - `sr_latch_ctrl` instantiates it and registers its result in IDLE.
- Top level holds the FSM, pulse counter, capture registers and the one-hot output decode.

## Test plan
- Reset, then req[2]=1, op=1, idx=5 → `latch_S[5]` high in cycles 1–4, `latch_en[5]` high in cycles 2–3, `ack[2]` in cycle 5, `err`=0.
- req[0], req[1] and req[3] all high from reset, each dropped after its ack → grants in order 0, 1, 3, with acks 6 cycles apart; `grant_id` matches each grant.
- req[1] idx=5 op=1, then req[1] idx=5 op=0 → the bank model shows Q5 = 1, then 0. R and S are never both high, and no other latch bit toggles.
- req[3] idx=7 op=1 with N_LATCH=6 → all latch outputs stay 0; `ack[3]` and `err` both pulse in cycle 5.
- Assert rst in cycle 2 of an access → `latch_en` and `busy` go 0 immediately, with no ack. After release, the first grant goes to requester 0 when req[0] and req[1] are both high.
- Change op/idx of the grantee during PULSE → the driven latch and R/S still match the values captured at grant.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch bank sequencing controller.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    localparam logic OP_RESET = 1'b0;
    localparam logic OP_SET   = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts at ptr+1 and wraps modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id
);

    localparam int GW = $clog2(N_REQ);

    // Walk from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (req[(int'(ptr) + off) % N_REQ]) begin
                gnt_valid = 1'b1;
                gnt_id    = GW'((int'(ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Arbitrates set/reset requests and sequences setup/enable-pulse/hold on a gated SR latch bank.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int N_LATCH   = 8,
    parameter int IDXW      = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         op,
    input  logic [N_REQ*IDXW-1:0]    idx,
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [N_LATCH-1:0]       latch_R,
    output logic [N_LATCH-1:0]       latch_S,
    output logic [N_LATCH-1:0]       latch_en
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            op_q;
    logic [IDXW-1:0] idx_q;
    logic            gnt_valid;
    logic [GW-1:0]   gnt_id;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= GW'(N_REQ - 1);
            cnt      <= '0;
            grant_id <= '0;
            op_q     <= OP_RESET;
            idx_q    <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    grant_id <= gnt_id;
                    op_q     <= op[gnt_id];
                    idx_q    <= idx[gnt_id*IDXW +: IDXW];
                    state    <= SETUP;
                end
                SETUP: begin
                    cnt   <= CW'(PULSE_CYC - 1);
                    state <= PULSE;
                end
                PULSE: begin
                    if (cnt == '0) state <= HOLD;
                    else           cnt   <= cnt - 1'b1;
                end
                HOLD: state <= DONE;
                DONE: begin
                    ptr   <= grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only from state and capture registers, so reset drops them at once.
    logic active;
    assign active = (state == SETUP) || (state == PULSE) || (state == HOLD);
    assign busy   = (state != IDLE);
    assign err    = (state == DONE) && (32'(idx_q) >= N_LATCH);

    always_comb begin
        latch_R  = '0;
        latch_S  = '0;
        latch_en = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (active && idx_q == IDXW'(i)) begin
                latch_S[i]  = (op_q == OP_SET);
                latch_R[i]  = (op_q == OP_RESET);
                latch_en[i] = (state == PULSE);
            end
        end
    end

    always_comb begin
        ack = '0;
        for (int k = 0; k < N_REQ; k++)
            ack[k] = (state == DONE) && (grant_id == GW'(k));
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed plus randomized bench for sr_latch_ctrl against a transaction-level model.
module tb_sr_latch_ctrl;

    localparam int NR = 4;
    localparam int NL = 6;
    localparam int IW = 3;
    localparam int P  = 2;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    op  = '0;
    logic [NR*IW-1:0] idx = '0;
    logic [NR-1:0]    ack;
    logic             err;
    logic             busy;
    logic [GW-1:0]    grant_id;
    logic [NL-1:0]    latch_R, latch_S, latch_en;

    sr_latch_ctrl #(.N_REQ(NR), .N_LATCH(NL), .IDXW(IW), .PULSE_CYC(P)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
        .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
        .latch_R(latch_R), .latch_S(latch_S), .latch_en(latch_en)
    );

    always #5 clk = ~clk;

    // Behavioural latch bank fed only by the DUT outputs.
    logic [NL-1:0] bank_q = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (latch_en[i] && latch_S[i])      bank_q[i] <= 1'b1;
            else if (latch_en[i] && latch_R[i]) bank_q[i] <= 1'b0;
        end
    end

    int npass = 0;
    int ntot  = 0;
    int ptr_m;
    logic [NL-1:0] q_m = '0;
    logic          rop  [NR];
    logic [IW-1:0] ridx [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NR; k++) begin
            op[k]           = rop[k];
            idx[k*IW +: IW] = ridx[k];
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r);
        for (int o = 1; o <= NR; o++)
            if (r[(ptr_m + o) % NR]) return (ptr_m + o) % NR;
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ack"},  32'(ack), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_rse"},  32'({latch_R, latch_S, latch_en}), 0);
        chk({tag, "_bank"}, 32'(bank_q), 32'(q_m));
    endtask

    // Runs one access from an IDLE cycle, checking every cycle until the following IDLE.
    task automatic access(input string tag, input bit perturb);
        int w;
        logic oc;
        logic [IW-1:0] ic;
        logic [NL-1:0] bitv;
        bit act, en, last;
        w = pick(req);
        if (w < 0) begin
            step();
            check_idle({tag, "_noreq"});
            return;
        end
        oc   = rop[w];
        ic   = ridx[w];
        bitv = (int'(ic) < NL) ? NL'(1 << ic) : '0;
        for (int c = 1; c <= 3 + P; c++) begin
            step();
            act  = (c <= 2 + P);
            en   = (c >= 2) && (c <= 1 + P);
            last = (c == 3 + P);
            chk({tag, "_bank"}, 32'(bank_q), 32'(q_m));
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_gid"},  32'(grant_id), 32'(w));
            chk({tag, "_S"},    32'(latch_S),  (act && oc)  ? 32'(bitv) : 0);
            chk({tag, "_R"},    32'(latch_R),  (act && !oc) ? 32'(bitv) : 0);
            chk({tag, "_en"},   32'(latch_en), en ? 32'(bitv) : 0);
            chk({tag, "_ack"},  32'(ack), last ? 32'(1 << w) : 0);
            chk({tag, "_err"},  32'(err), 32'(last && int'(ic) >= NL));
            if (en && int'(ic) < NL) q_m[ic] = oc;
            if (perturb && c == 2) begin
                op[w]           = ~op[w];
                idx[w*IW +: IW] = IW'($urandom);
            end
            if (last) begin
                req[w] = 1'b0;
                ptr_m  = w;
            end
        end
        step();
        check_idle({tag, "_post"});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        step();
        step();
        check_idle(tag);
        chk({tag, "_gid"}, 32'(grant_id), 0);
        rst   = 1'b0;
        ptr_m = NR - 1;
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            rop[k]  = 1'b0;
            ridx[k] = '0;
        end
        do_reset("reset");

        // Basic set of latch 5 from requester 2.
        rop[2] = 1'b1; ridx[2] = 3'd5; drive_inputs();
        req = 4'b0100;
        access("t1", 1'b0);

        // Three simultaneous requesters from reset: 0, 1, 3 in turn.
        do_reset("reset2");
        rop[0] = 1'b1; ridx[0] = 3'd0;
        rop[1] = 1'b1; ridx[1] = 3'd2;
        rop[3] = 1'b1; ridx[3] = 3'd4;
        drive_inputs();
        req = 4'b1011;
        access("rr_a", 1'b0);
        access("rr_b", 1'b0);
        access("rr_c", 1'b0);

        // Set then reset latch 5 from the same requester.
        rop[1] = 1'b1; ridx[1] = 3'd5; drive_inputs(); req = 4'b0010;
        access("t3_set", 1'b0);
        rop[1] = 1'b0; drive_inputs(); req = 4'b0010;
        access("t3_clr", 1'b0);

        // Out-of-range index: full timing, no drive, err with ack.
        rop[3] = 1'b1; ridx[3] = 3'd7; drive_inputs(); req = 4'b1000;
        access("t4_bad", 1'b0);

        // Grantee changes op/idx mid-pulse.
        rop[0] = 1'b1; ridx[0] = 3'd2; drive_inputs(); req = 4'b0001;
        access("t6_chg", 1'b1);
        drive_inputs();

        // Reset in cycle 2 of an access.
        rop[2] = 1'b1; ridx[2] = 3'd1; drive_inputs(); req = 4'b0100;
        step();
        chk("t5_c1_S", 32'(latch_S), 32'h2);
        step();
        chk("t5_c2_en", 32'(latch_en), 32'h2);
        q_m[1] = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_en",   32'(latch_en), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ack",  32'(ack), 0);
        req = '0;
        step();
        step();
        check_idle("t5_held");
        rst   = 1'b0;
        ptr_m = NR - 1;
        req   = 4'b0011;
        access("t5_first", 1'b0);
        access("t5_second", 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NR; k++) begin
                if (!req[k] && ($urandom_range(0, 1) == 1)) begin
                    rop[k]  = 1'($urandom);
                    ridx[k] = IW'($urandom);
                    req[k]  = 1'b1;
                end
            end
            drive_inputs();
            access("rnd", 1'($urandom_range(0, 1)));
            drive_inputs();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
